bit_serial_mac: RTL and testbench
=================================

// Module: bit_serial_mac
// PURPOSE
//  Bit-serial multiply-accumulate lane; the stage directly upstream of relu_activation.
//  Accepts a stream of signed (activation, weight) pairs terminated by in_last.
//  Each product is formed serially over the activation bits.
//  The signed dot-product is presented on a valid/ready output that connects directly to the ReLU input.
// PARAMETERS
//  DATA_W  8   width of signed activation and weight operands (>=2)
//  ACC_W   64  width of signed accumulator and out_data (>= 2*DATA_W)
//  CNT_W   $clog2(DATA_W)  bit-index counter width (derived localparam, not overridable)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_act     in   DATA_W  signed activation operand
//  in_wgt     in   DATA_W  signed weight operand
//  in_last    in   1       marks final pair of the current vector
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       lane can accept a pair this cycle
//  out_data   out  ACC_W   signed dot-product result
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; accumulator, operand regs, bit counter and last flag all cleared.
//   Outputs during and after reset: out_valid=0, out_data=0, in_ready=0 while rst_n=0, in_ready=1 after release.
//  FSM states: IDLE, SHIFT, OUT.
//  IDLE: in_ready=1.
//   - On in_valid: latch act, wgt and in_last; clear bit counter; go to SHIFT.
//   - No in_valid: stay in IDLE.
//  SHIFT: exactly DATA_W cycles, bit index i = 0..DATA_W-1; in_ready=0.
//   - Let pp = sign_extend(wgt, ACC_W) << i.
//   - If act[i]=1 and i<DATA_W-1: acc += pp.
//   - If act[i]=1 and i=DATA_W-1: acc -= pp (two's-complement MSB weighting).
//   - After cycle i=DATA_W-1: go to OUT if the latched last flag is set, otherwise back to IDLE.
//  OUT: out_valid=1 and out_data=acc; in_ready=0.
//   - out_data is held stable while out_ready=0, for any number of cycles.
//   - On out_valid & out_ready: clear acc to 0; go to IDLE. out_valid drops in the next cycle.
//  Latency and throughput:
//   - A pair accepted at edge t is fully accumulated by edge t+DATA_W.
//   - out_valid rises at edge t+DATA_W after the last pair is accepted (9 cycles for DATA_W=8).
//   - Throughput is one pair per DATA_W+1 cycles.
//  Arithmetic:
//   - All arithmetic is signed, ACC_W bits, and wraps modulo 2^ACC_W.
//   - No saturation and no overflow flag.
//   - The product is exact for all operand values, including -2^(DATA_W-1) * -2^(DATA_W-1).
//  Operands are sampled only on the IDLE handshake; input changes at any other time are ignored.
//  in_valid asserted in SHIFT or OUT is ignored, since in_ready=0; the upstream block must hold the pair.
//  Operand value does not shorten SHIFT: act=0 still takes DATA_W cycles.
//  A vector of one pair (in_last on the first pair) is legal. Empty vectors cannot occur.
//  Reset asserted mid-SHIFT or mid-OUT aborts the vector immediately. No partial result is emitted.
// STRUCTURE
//  Shared package bsnc_pkg holds:
//   - typedef enum logic [1:0] {IDLE, SHIFT, OUT} mac_state_e;
//   - default width constants DATA_W_DEF=8 and ACC_W_DEF=64, shared with relu_activation.
//  One sub-module: bs_shift_add.
//   - Combinational: given acc, wgt, act_bit, bit index and is_msb, it returns the next acc.
//   - The top level holds the FSM, counter, operand registers and handshakes.
// TESTING (DATA_W=8, ACC_W=64 unless noted)
//  1 Single pair: act=3, wgt=5, last=1 -> out_data=15; out_valid rises 9 cycles after acceptance.
//  2 Sign corners, each a one-pair vector:
//    - (-128,-128) -> 16384
//    - (-1,127) -> -127
//    - (0,-77) -> 0, still 9-cycle latency
//  3 Vector of 4 pairs: (1,2),(3,4),(-5,6),(7,-8) -> out_data=-72.
//    - in_ready low during every SHIFT.
//    - Pairs accepted 9 cycles apart.
//  4 Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//    - out_valid and out_data stay stable; in_ready stays 0.
//    - On the handshake, acc clears; the next vector (2,2),last -> 4.
//  5 Async reset: assert rst_n=0 mid-SHIFT of the 2nd pair.
//    - out_valid=0 and out_data=0 with no clock edge needed.
//    - After release, vector (10,10),last -> 100.
//  6 Wrap with ACC_W=16: three pairs (-128,-128) -> 49152 mod 2^16 = out_data=-16384.

Source files
------------

// File: rtl/bsnc_pkg.sv
// Shared types and default widths for the bit-serial MAC lane and the ReLU stage after it.
package bsnc_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} mac_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 64;

endpackage

// File: rtl/bit_serial_mac_if.sv
// Operand-in / result-out handshake bundle for the bit-serial MAC lane.
interface bit_serial_mac_if
    import bsnc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic signed [DATA_W-1:0] in_act;
    logic signed [DATA_W-1:0] in_wgt;
    logic                     in_last;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_act, in_wgt, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_act, in_wgt, in_last, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/bs_shift_add.sv
// One bit-serial step: conditionally adds (or, for the sign bit, subtracts) the shifted weight.
module bs_shift_add #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 64
) (
    input  logic signed [ACC_W-1:0]         i_acc,
    input  logic signed [DATA_W-1:0]        i_wgt,
    input  logic                            i_act_bit,
    input  logic [$clog2(DATA_W)-1:0]       i_bit_idx,
    input  logic                            i_is_msb,
    output logic signed [ACC_W-1:0]         o_acc_nxt
);
    logic signed [ACC_W-1:0] w_wgt_ext;
    logic signed [ACC_W-1:0] w_pp;

    assign w_wgt_ext = {{(ACC_W-DATA_W){i_wgt[DATA_W-1]}}, i_wgt};
    assign w_pp      = w_wgt_ext << i_bit_idx;

    // The activation MSB carries weight -2^(DATA_W-1), hence the subtract.
    always_comb begin
        o_acc_nxt = i_acc;
        if (i_act_bit) begin
            o_acc_nxt = i_is_msb ? (i_acc - w_pp) : (i_acc + w_pp);
        end
    end
endmodule

// File: rtl/bit_serial_mac.sv
// Bit-serial signed multiply-accumulate lane: one activation bit per cycle, dot product out on last.
//   state | meaning
//   IDLE  | ready for the next (act, wgt) pair
//   SHIFT | walking activation bits 0..DATA_W-1 into the accumulator
//   OUT   | result presented, waiting for downstream to take it
module bit_serial_mac
    import bsnc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_serial_mac_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    mac_state_e               r_state;
    mac_state_e               w_state_nxt;
    logic signed [DATA_W-1:0] r_act;
    logic signed [DATA_W-1:0] r_wgt;
    logic                     r_last;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_shift;
    logic                     w_is_msb;
    logic                     w_accept;
    logic                     w_out_fire;

    assign w_is_msb   = (r_cnt == CNT_W'(DATA_W-1));
    assign w_accept   = (r_state == IDLE) && bus.in_valid;
    assign w_out_fire = (r_state == OUT) && bus.out_ready;

    bs_shift_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_shift_add (
        .i_acc     (r_acc),
        .i_wgt     (r_wgt),
        .i_act_bit (r_act[r_cnt]),
        .i_bit_idx (r_cnt),
        .i_is_msb  (w_is_msb),
        .o_acc_nxt (w_acc_shift)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_is_msb)     w_state_nxt = r_last ? OUT : IDLE;
            OUT:     if (bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_act   <= '0;
            r_wgt   <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_act  <= bus.in_act;
                r_wgt  <= bus.in_wgt;
                r_last <= bus.in_last;
                r_cnt  <= '0;
            end
            if (r_state == SHIFT) begin
                r_acc <= w_acc_shift;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_out_fire) begin
                r_acc <= '0;
            end
        end
    end

    // in_ready follows rst_n directly so it is low throughout reset.
    assign bus.in_ready  = rst_n && (r_state == IDLE);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_data  = (r_state == OUT) ? r_acc : '0;
endmodule

// File: tb/tb_bit_serial_mac.sv
// Directed bench for bit_serial_mac; a 64-bit and a 16-bit lane run in lockstep on the same stimulus.
module tb_bit_serial_mac;
    import bsnc_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 64;
    localparam int AW16 = 16;
    localparam int TMO  = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int acc_cyc = 0;

    logic signed [DW-1:0] s_act    = '0;
    logic signed [DW-1:0] s_wgt    = '0;
    logic                 s_last   = 1'b0;
    logic                 s_valid  = 1'b0;
    logic                 s_oready = 1'b0;

    bit_serial_mac_if #(.DATA_W(DW), .ACC_W(AW))   bus();
    bit_serial_mac_if #(.DATA_W(DW), .ACC_W(AW16)) bus16();

    assign bus.in_act     = s_act;
    assign bus.in_wgt     = s_wgt;
    assign bus.in_last    = s_last;
    assign bus.in_valid   = s_valid;
    assign bus.out_ready  = s_oready;
    assign bus16.in_act    = s_act;
    assign bus16.in_wgt    = s_wgt;
    assign bus16.in_last   = s_last;
    assign bus16.in_valid  = s_valid;
    assign bus16.out_ready = s_oready;

    bit_serial_mac #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bit_serial_mac #(.DATA_W(DW), .ACC_W(AW16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send_pair(input logic signed [DW-1:0] a, input logic signed [DW-1:0] w,
                             input logic l);
        int n = 0;
        s_act = a; s_wgt = w; s_last = l; s_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (n >= TMO) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < TMO) begin
            @(posedge clk); #1; n++;
        end
        if (n >= TMO) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, n);
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic pop();
        s_oready = 1'b1;
        @(posedge clk); #1;
        s_oready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_in_ready: got %b, required 0", bus.in_ready);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid);
        end
        n_vec++;
        if (bus.out_data !== 64'sd0) begin
            n_err++; $display("FAIL rst_out_data: got %0d, required 0", bus.out_data);
        end
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rel_in_ready: got %b, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat;
        send_pair(8'sd3, 8'sd5, 1'b1);
        wait_result(lat);
        n_vec++;
        if (bus.out_data !== 64'sd15) begin
            n_err++; $display("FAIL single_data: got %0d, required 15", bus.out_data);
        end
        // result visible after edge t+DATA_W, the 9th edge counting the acceptance edge
        n_vec++;
        if (lat !== DW) begin
            n_err++; $display("FAIL single_latency: got %0d, required %0d", lat, DW);
        end
        pop();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_drop: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_sign_corners();
        logic signed [DW-1:0] ta [3];
        logic signed [DW-1:0] tw [3];
        logic signed [AW-1:0] te [3];
        int lat;
        ta = '{-8'sd128, -8'sd1, 8'sd0};
        tw = '{-8'sd128, 8'sd127, -8'sd77};
        te = '{64'sd16384, -64'sd127, 64'sd0};
        for (int k = 0; k < 3; k++) begin
            send_pair(ta[k], tw[k], 1'b1);
            wait_result(lat);
            n_vec++;
            if (bus.out_data !== te[k]) begin
                n_err++; $display("FAIL corner%0d_data: got %0d, required %0d", k, bus.out_data, te[k]);
            end
            n_vec++;
            if (lat !== DW) begin
                n_err++; $display("FAIL corner%0d_latency: got %0d, required %0d", k, lat, DW);
            end
            pop();
        end
    endtask

    task automatic test_vector();
        logic signed [DW-1:0] ta [4];
        logic signed [DW-1:0] tw [4];
        int prev_acc;
        int lat;
        logic bad;
        ta = '{8'sd1, 8'sd3, -8'sd5, 8'sd7};
        tw = '{8'sd2, 8'sd4, 8'sd6, -8'sd8};
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            send_pair(ta[k], tw[k], k == 3);
            if (k > 0) begin
                n_vec++;
                if (acc_cyc - prev_acc !== DW + 1) begin
                    n_err++; $display("FAIL vec_spacing%0d: got %0d cycles, required %0d", k, acc_cyc - prev_acc, DW + 1);
                end
            end
            prev_acc = acc_cyc;
            bad = 1'b0;
            for (int j = 0; j < DW - 1; j++) begin
                if (bus.in_ready !== 1'b0) bad = 1'b1;
                @(posedge clk); #1;
            end
            if (bus.in_ready !== 1'b0) bad = 1'b1;
            n_vec++;
            if (bad) begin
                n_err++; $display("FAIL vec_shift_ready%0d: in_ready seen high in SHIFT, required 0", k);
            end
        end
        wait_result(lat);
        n_vec++;
        if (bus.out_data !== -64'sd72) begin
            n_err++; $display("FAIL vec_data: got %0d, required -72", bus.out_data);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        send_pair(-8'sd3, 8'sd9, 1'b1);
        wait_result(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== -64'sd27 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d in_ready=%b, required 1/-27/0",
                         k, bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        pop();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drop: out_valid=%b, required 0", bus.out_valid);
        end
        send_pair(8'sd2, 8'sd2, 1'b1);
        wait_result(lat);
        n_vec++;
        if (bus.out_data !== 64'sd4) begin
            n_err++; $display("FAIL bp_next_data: got %0d, required 4", bus.out_data);
        end
        pop();
    endtask

    task automatic test_async_reset();
        int lat;
        send_pair(8'sd1, 8'sd1, 1'b0);
        send_pair(8'sd50, 8'sd3, 1'b1);
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'sd0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arst_outputs: valid=%b data=%0d in_ready=%b, required 0/0/0",
                     bus.out_valid, bus.out_data, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_pair(8'sd10, 8'sd10, 1'b1);
        wait_result(lat);
        n_vec++;
        if (bus.out_data !== 64'sd100) begin
            n_err++; $display("FAIL arst_next_data: got %0d, required 100", bus.out_data);
        end
        pop();
    endtask

    task automatic test_wrap();
        logic signed [AW16-1:0] exp16;
        int lat;
        exp16 = -16'sd16384;
        for (int k = 0; k < 3; k++) begin
            send_pair(-8'sd128, -8'sd128, k == 2);
        end
        wait_result(lat);
        n_vec++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== exp16) begin
            n_err++; $display("FAIL wrap16_data: valid=%b data=%0d, required 1/-16384", bus16.out_valid, bus16.out_data);
        end
        n_vec++;
        if (bus.out_data !== 64'sd49152) begin
            n_err++; $display("FAIL wrap64_data: got %0d, required 49152", bus.out_data);
        end
        pop();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign_corners();
        test_vector();
        test_backpressure();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
